fxp_dot_accumulator: RTL and testbench
======================================

// Module: fxp_dot_accumulator
// PURPOSE
//  Sequential fixed-point dot-product engine for the Kalman datapath (row x column of P, H, K products).
//  Accepts a stream of (a,b) operand pairs, multiplies each through qmult and accumulates the products
//  with saturation. Returns one Q-format sum per vector. Sits directly downstream of qmult and consumes
//  its o_result/ovr.
// PARAMETERS
//  Q      18  fractional bits, matches qmult
//  N      32  word width, two's complement, matches qmult
//  LEN_W  5   width of vector-length field; max terms = 2^LEN_W-1
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  i_start    in   1      begin new vector; sampled only in IDLE
//  i_len      in   LEN_W  number of terms in vector, latched with i_start
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      engine accepts operand pair
//  in_a       in   N      operand a, Q format
//  in_b       in   N      operand b, Q format
//  out_valid  out  1      o_result/o_ovr valid
//  out_ready  in   1      consumer takes result
//  o_result   out  N      saturated accumulated sum, Q format
//  o_ovr      out  1      sticky: any product or accumulation overflowed in this vector
//  o_busy     out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; in_ready, out_valid, o_ovr, o_busy=0; o_result, acc, counters=0.
//  FSM states: IDLE, ACCUM, DRAIN, DONE.
//   IDLE : i_start=1 -> latch i_len, clear acc, sticky ovr, term count. Go to ACCUM, or to DONE if i_len=0
//          (result 0, o_ovr=0, out_valid on next cycle).
//   ACCUM: in_ready=1 while accepted < len. Beat = in_valid & in_ready. Product comes from qmult
//          instance (combinational) and is registered into stage P with p_valid, p_ovr, p_last.
//          On the last accepted beat, in_ready drops next cycle. Go to DRAIN.
//   DRAIN: wait until the stage-P product of the last beat has been added. Go to DONE.
//   DONE : out_valid=1; o_result/o_ovr held stable until out_ready=1. Then -> IDLE, out_valid=0.
//  i_start outside IDLE is ignored; no abort except reset. in_valid while in_ready=0 is ignored.
//  Product saturation: if qmult ovr=1, use sat product instead: 0x7FF..F if sign(a)^sign(b)=0,
//   else 0x800..0. Set sticky ovr. Otherwise use qmult o_result (truncation toward zero).
//  Accumulate stage: sum = sext(acc)+sext(p), N+1 bits. If sum > 2^(N-1)-1, clamp to max and set ovr.
//   If sum < -2^(N-1), clamp to min and set ovr. After saturation, later terms keep adding to the
//   clamped value; ovr stays 1.
//  Latency: last beat accepted at edge t -> stage P at t -> acc updated at t+1 -> out_valid=1 from t+2.
//  Throughput: 1 term/cycle; no bubble required between consecutive beats.
//  Back-to-back: the next i_start is accepted in the cycle after the DONE handshake (IDLE).
//  Reset mid-vector: all state discarded; no out_valid is produced for the partial vector.
// STRUCTURE
//  Shared package fxp_pkg: Q, N constants, FXP_MAX/FXP_MIN saturation constants, FSM state enum.
//  Sub-module: qmult (Q,N passed through), one instance on in_a/in_b. The FSM, product register,
//  saturating adder, and handshake logic are all in this module.
// TESTING (Q=18, N=32; 1.0 = 0x00040000)
//  1 len=3; (1.0,1.0),(1.5,2.0),(-0.5,1.0), in_valid held 1 -> o_result=0x000E0000 (3.5),
//    o_ovr=0, out_valid 2 cycles after last beat.
//  2 len=2; (0x7FFF0000,1.0) twice -> o_result=0x7FFFFFFF, o_ovr=1. Mirror with negative operand ->
//    o_result=0x80000000, o_ovr=1.
//  3 len=1; (0x10000000,0x10000000): qmult ovr -> o_result=0x7FFFFFFF, o_ovr=1.
//    With (0x10000000,-0x10000000) -> 0x80000000, o_ovr=1.
//  4 len=0 start -> out_valid next cycle, o_result=0, o_ovr=0.
//    i_start pulsed during ACCUM -> ignored; the result is unchanged.
//  5 len=4 with random in_valid gaps; out_ready held low 5 cycles -> outputs stable; exactly 4 beats
//    accepted; sum is correct; one handshake.
//  6 rst_n low for 1 cycle after 2 of 4 beats -> all outputs 0 immediately. A fresh len=1 vector
//    (2.0,0.25) -> 0x00020000 (0.5).

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions for the Kalman datapath.
//  FXP_Q / FXP_N   : fractional bits and word width (two's complement)
//  FXP_LEN_W       : width of the vector-length field of the dot-product engine
//  FXP_MAX/FXP_MIN : saturation limits for an FXP_N-bit word
//  dot_state_e     : control states of the dot-product engine
package fxp_pkg;

   localparam int unsigned FXP_Q     = 18;
   localparam int unsigned FXP_N     = 32;
   localparam int unsigned FXP_LEN_W = 5;

   localparam logic [FXP_N-1:0] FXP_MAX = {1'b0, {(FXP_N-1){1'b1}}};
   localparam logic [FXP_N-1:0] FXP_MIN = {1'b1, {(FXP_N-1){1'b0}}};

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StDrain,
      StDone
   } dot_state_e;

endpackage

// File: rtl/qmult.sv
// Combinational signed fixed-point multiplier.
//  i_multiplicand, i_multiplier : N-bit two's complement operands, Q fractional bits
//  o_result                     : product rescaled to Q, truncated toward zero
//  ovr                          : product magnitude does not fit in N bits (o_result invalid)
module qmult #(
   parameter int unsigned Q = 18,
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] i_multiplicand,
   input  logic [N-1:0] i_multiplier,
   output logic [N-1:0] o_result,
   output logic         ovr
);

   logic [N-1:0]   mag_a;
   logic [N-1:0]   mag_b;
   logic [2*N-1:0] prod;
   logic [2*N-1:0] scaled;
   logic           neg;

   // Working on magnitudes makes the right shift truncate toward zero for both signs.
   always_comb begin
      mag_a  = i_multiplicand[N-1] ? (~i_multiplicand + 1'b1) : i_multiplicand;
      mag_b  = i_multiplier[N-1]   ? (~i_multiplier + 1'b1)   : i_multiplier;
      prod   = {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b};
      scaled = prod >> Q;
      neg    = i_multiplicand[N-1] ^ i_multiplier[N-1];
      // Magnitude 2^(N-1) is flagged too; callers saturate it to the same minimum value.
      ovr      = |scaled[2*N-1:N-1];
      o_result = neg ? (~scaled[N-1:0] + 1'b1) : scaled[N-1:0];
   end

endmodule

// File: rtl/fxp_dot_accumulator.sv
// Sequential saturating fixed-point dot-product engine.
//  clk, rst_n            : clock, asynchronous active-low reset
//  i_start, i_len        : start a vector of i_len terms (sampled in idle only)
//  in_valid/in_ready     : operand pair handshake, in_a/in_b in Q format
//  out_valid/out_ready   : result handshake, o_result/o_ovr held until taken
//  o_result, o_ovr       : saturated sum and sticky overflow of the vector
//  o_busy                : engine is not idle
module fxp_dot_accumulator
   import fxp_pkg::*;
#(
   parameter int unsigned Q     = FXP_Q,
   parameter int unsigned N     = FXP_N,
   parameter int unsigned LEN_W = FXP_LEN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     o_result,
   output logic             o_ovr,
   output logic             o_busy
);

   localparam logic [N-1:0] SatMax = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] SatMin = {1'b1, {(N-1){1'b0}}};

   dot_state_e       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     acc_q, acc_d;
   logic             ovr_q, ovr_d;
   logic [N-1:0]     p_q, p_d;
   logic             p_valid_q, p_valid_d;
   logic             p_ovr_q, p_ovr_d;
   logic             p_last_q, p_last_d;

   logic [N-1:0]     mult_res;
   logic             mult_ovr;
   logic [N-1:0]     p_sat;
   logic [N:0]       sum;
   logic             sum_ovf;
   logic [N-1:0]     sum_sat;
   logic             beat;
   logic             last_beat;

   qmult #(
      .Q(Q),
      .N(N)
   ) u_qmult (
      .i_multiplicand(in_a),
      .i_multiplier  (in_b),
      .o_result      (mult_res),
      .ovr           (mult_ovr)
   );

   assign in_ready  = (state_q == StAccum) && (cnt_q < len_q);
   assign beat      = in_valid && in_ready;
   assign last_beat = beat && (cnt_q == len_q - LEN_W'(1));

   always_comb begin
      // Saturated product: sign follows the operand signs, not the wrapped qmult output.
      p_sat   = mult_ovr ? ((in_a[N-1] ^ in_b[N-1]) ? SatMin : SatMax) : mult_res;
      // One extra bit catches both overflow directions of the signed add.
      sum     = {acc_q[N-1], acc_q} + {p_q[N-1], p_q};
      sum_ovf = sum[N] ^ sum[N-1];
      sum_sat = sum_ovf ? (sum[N] ? SatMin : SatMax) : sum[N-1:0];
   end

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      ovr_d     = ovr_q;
      p_d       = p_q;
      p_valid_d = 1'b0;
      p_ovr_d   = 1'b0;
      p_last_d  = 1'b0;

      if (p_valid_q) begin
         acc_d = sum_sat;
         ovr_d = ovr_q | p_ovr_q | sum_ovf;
      end

      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               len_d   = i_len;
               cnt_d   = '0;
               acc_d   = '0;
               ovr_d   = 1'b0;
               state_d = (i_len == '0) ? StDone : StAccum;
            end
         end
         StAccum: begin
            if (beat) begin
               p_d       = p_sat;
               p_valid_d = 1'b1;
               p_ovr_d   = mult_ovr;
               p_last_d  = last_beat;
               cnt_d     = cnt_q + LEN_W'(1);
               if (last_beat) state_d = StDrain;
            end
         end
         StDrain: begin
            // The last product is folded into acc on this edge.
            if (p_valid_q && p_last_q) state_d = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         len_q     <= '0;
         cnt_q     <= '0;
         acc_q     <= '0;
         ovr_q     <= 1'b0;
         p_q       <= '0;
         p_valid_q <= 1'b0;
         p_ovr_q   <= 1'b0;
         p_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         ovr_q     <= ovr_d;
         p_q       <= p_d;
         p_valid_q <= p_valid_d;
         p_ovr_q   <= p_ovr_d;
         p_last_q  <= p_last_d;
      end
   end

   assign out_valid = (state_q == StDone);
   assign o_busy    = (state_q != StIdle);
   assign o_result  = acc_q;
   assign o_ovr     = ovr_q;

endmodule

// File: tb/tb_fxp_dot_accumulator.sv
module tb_fxp_dot_accumulator;

   logic        clk;
   logic        rst_n;
   logic        i_start;
   logic [4:0]  i_len;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] o_result;
   logic        o_ovr;
   logic        o_busy;

   int total = 0;
   int bad   = 0;
   int beats = 0;
   int hands = 0;

   fxp_dot_accumulator dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (i_start),
      .i_len    (i_len),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .o_result (o_result),
      .o_ovr    (o_ovr),
      .o_busy   (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Handshake monitors; inputs change #1 after the edge, so these see pre-edge values.
   always @(posedge clk) begin
      if (in_valid && in_ready) beats <= beats + 1;
      if (out_valid && out_ready) hands <= hands + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [4:0] len);
      i_start = 1'b1;
      i_len   = len;
      step();
      i_start = 1'b0;
   endtask

   // Present a pair and return #1 after the edge that accepted it.
   task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b);
      int n;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      n        = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
      step();
   endtask

   task automatic wait_out(input string tag);
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
         step();
         n++;
      end
      check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
   endtask

   task automatic take(input string tag, input logic [31:0] res, input logic ovr);
      wait_out(tag);
      check({tag, "_result"}, o_result, res);
      check({tag, "_ovr"}, 32'(o_ovr), 32'(ovr));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_idle"}, 32'({out_valid, o_busy}), 32'd0);
   endtask

   initial begin
      logic [31:0] held;
      int          b0;
      int          h0;
      rst_n     = 1'b0;
      i_start   = 1'b0;
      i_len     = '0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;

      // Reset state
      #2;
      check("rst_result", o_result, 32'h0);
      check("rst_flags", 32'({in_ready, out_valid, o_ovr, o_busy}), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // 1: 1.0*1.0 + 1.5*2.0 + (-0.5)*1.0 = 3.5, exact latency
      start(5'd3);
      check("t1_busy", 32'({o_busy, in_ready}), 32'b11);
      send("t1", 32'h0004_0000, 32'h0004_0000);
      send("t1", 32'h0006_0000, 32'h0008_0000);
      send("t1", 32'hFFFE_0000, 32'h0004_0000);
      in_valid = 1'b0;
      check("t1_drain", 32'({out_valid, in_ready}), 32'd0);
      step();
      check("t1_latency", 32'(out_valid), 32'd1);
      take("t1", 32'h000E_0000, 1'b0);

      // 2: accumulation saturates both ways
      start(5'd2);
      send("t2p", 32'h7FFF_0000, 32'h0004_0000);
      send("t2p", 32'h7FFF_0000, 32'h0004_0000);
      in_valid = 1'b0;
      take("t2p", 32'h7FFF_FFFF, 1'b1);
      start(5'd2);
      send("t2n", 32'h8001_0000, 32'h0004_0000);
      send("t2n", 32'h8001_0000, 32'h0004_0000);
      in_valid = 1'b0;
      take("t2n", 32'h8000_0000, 1'b1);

      // 3: product overflow in qmult
      start(5'd1);
      send("t3p", 32'h1000_0000, 32'h1000_0000);
      in_valid = 1'b0;
      take("t3p", 32'h7FFF_FFFF, 1'b1);
      start(5'd1);
      send("t3n", 32'h1000_0000, 32'hF000_0000);
      in_valid = 1'b0;
      take("t3n", 32'h8000_0000, 1'b1);

      // 4: zero-length vector, then i_start ignored mid-vector
      start(5'd0);
      check("t4_len0_valid", 32'(out_valid), 32'd1);
      take("t4_len0", 32'h0, 1'b0);
      start(5'd2);
      send("t4", 32'h0004_0000, 32'h0004_0000);
      in_valid = 1'b0;
      i_start  = 1'b1;
      i_len    = 5'd0;
      step();
      i_start = 1'b0;
      check("t4_ignored_start", 32'({o_busy, in_ready, out_valid}), 32'b110);
      send("t4", 32'h0004_0000, 32'h0002_0000);
      in_valid = 1'b0;
      take("t4", 32'h0006_0000, 1'b0);

      // 5: gaps on input, stalled output; 0.5 + 4.0 - 0.25 + 3.0 = 7.25
      b0 = beats;
      start(5'd4);
      send("t5", 32'h0004_0000, 32'h0002_0000);
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) step();
      send("t5", 32'h0008_0000, 32'h0008_0000);
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) step();
      send("t5", 32'hFFFC_0000, 32'h0001_0000);
      send("t5", 32'h000C_0000, 32'h0004_0000);
      // Keep offering a junk pair; it must not be taken.
      in_a = 32'h0040_0000;
      in_b = 32'h0040_0000;
      wait_out("t5");
      h0   = hands;
      held = o_result;
      check("t5_result", o_result, 32'h001D_0000);
      repeat (5) begin
         step();
         check("t5_stable", {o_result[31:1], o_result[0] ^ o_ovr}, {held[31:1], held[0]});
         check("t5_hold_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      check("t5_beats", 32'(beats - b0), 32'd4);
      take("t5", 32'h001D_0000, 1'b0);
      check("t5_handshakes", 32'(hands - h0), 32'd1);

      // 6: reset mid-vector, then a fresh vector 2.0*0.25 = 0.5
      start(5'd4);
      send("t6", 32'h0004_0000, 32'h0004_0000);
      send("t6", 32'h0004_0000, 32'h0004_0000);
      in_valid = 1'b0;
      check("t6_partial", o_result, 32'h0004_0000);
      rst_n = 1'b0;
      #1;
      check("t6_rst_result", o_result, 32'h0);
      check("t6_rst_flags", 32'({in_ready, out_valid, o_ovr, o_busy}), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      step();
      check("t6_no_stale", 32'({out_valid, o_busy}), 32'd0);
      start(5'd1);
      send("t6", 32'h0008_0000, 32'h0001_0000);
      in_valid = 1'b0;
      take("t6", 32'h0002_0000, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
